// File: rtl/hps_button_event_ctrl_if.sv
// Avalon-MM slave bus plus level interrupt between the HPS bridge and the button event controller.
interface hps_button_event_ctrl_if;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (output address, read, write, writedata, input readdata, irq);
    modport slave  (input address, read, write, writedata, output readdata, irq);
endinterface

// File: rtl/hps_button_event_ctrl.sv
// Debounces raw KEY levels into press/release events, queues them in a small FIFO and exposes
// the queue, current levels, interrupt mask and status to software over Avalon-MM.
module hps_button_event_ctrl #(
    parameter int unsigned        NUM_BTN         = 4,
    parameter int unsigned        DEBOUNCE_CYCLES = 500000,
    parameter int unsigned        CNT_W           = 19,
    parameter int unsigned        FIFO_DEPTH      = 8,
    parameter logic [NUM_BTN-1:0] IDLE_LEVEL      = {NUM_BTN{1'b1}}
) (
    input  logic                   clk,
    input  logic                   reset,
    hps_button_event_ctrl_if.slave bus,
    input  logic [NUM_BTN-1:0]     in_port
);

    localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned COUNT_W = PTR_W + 1;
    localparam int unsigned ENTRY_W = 5;

    localparam logic [CNT_W-1:0]   DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [COUNT_W-1:0] FULL_CNT  = COUNT_W'(FIFO_DEPTH);
    localparam logic [1:0]         ADDR_LEVEL  = 2'd0;
    localparam logic [1:0]         ADDR_EVENT  = 2'd1;
    localparam logic [1:0]         ADDR_MASK   = 2'd2;
    localparam logic [1:0]         ADDR_STATUS = 2'd3;

    logic [NUM_BTN-1:0] sync_q1;
    logic [NUM_BTN-1:0] sync_q2;
    logic [NUM_BTN-1:0] stable;
    logic [NUM_BTN-1:0] pending;
    logic [CNT_W-1:0]   cnt [NUM_BTN];
    logic [NUM_BTN-1:0] accept_c;

    logic               sel_valid_c;
    logic [NUM_BTN-1:0] sel_onehot_c;
    logic [ENTRY_W-1:0] sel_entry_c;

    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [COUNT_W-1:0] count;
    logic               overflow;
    logic [1:0]         mask;

    logic rd_req_c, wr_req_c, empty_c, full_c, pop_c, push_c, drop_c, ovf_clr_c;
    logic unused_wdata_c;

    // Two-flop synchroniser on the asynchronous pins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q1 <= IDLE_LEVEL;
            sync_q2 <= IDLE_LEVEL;
        end else begin
            sync_q1 <= in_port;
            sync_q2 <= sync_q1;
        end
    end

    always_comb begin
        accept_c = '0;
        for (int i = 0; i < int'(NUM_BTN); i++) begin
            accept_c[i] = (sync_q2[i] != stable[i]) && (cnt[i] == DEB_LAST);
        end
    end

    // A new level is accepted only after DEBOUNCE_CYCLES consecutive differing samples
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable <= IDLE_LEVEL;
            for (int i = 0; i < int'(NUM_BTN); i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_BTN); i++) begin
                if (sync_q2[i] == stable[i] || accept_c[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
                if (accept_c[i]) stable[i] <= sync_q2[i];
            end
        end
    end

    // Lowest-index pending button wins the single enqueue slot
    always_comb begin
        sel_valid_c  = 1'b0;
        sel_onehot_c = '0;
        sel_entry_c  = '0;
        for (int i = int'(NUM_BTN) - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel_valid_c  = 1'b1;
                sel_onehot_c = NUM_BTN'(1) << i;
                sel_entry_c  = {stable[i], 4'(i)};
            end
        end
    end

    // Selected bit clears whether or not its push lands in the FIFO
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pending <= '0;
        else       pending <= (pending & ~sel_onehot_c) | accept_c;
    end

    always_comb begin
        rd_req_c  = bus.read;
        wr_req_c  = bus.write & ~bus.read;
        empty_c   = (count == '0);
        full_c    = (count == FULL_CNT);
        pop_c     = rd_req_c && (bus.address == ADDR_EVENT) && !empty_c;
        push_c    = sel_valid_c && (!full_c || pop_c);
        drop_c    = sel_valid_c && full_c && !pop_c;
        ovf_clr_c = wr_req_c && (bus.address == ADDR_STATUS) && bus.writedata[8];
    end

    assign unused_wdata_c = ^{bus.writedata[31:9], bus.writedata[7:2]};

    always_ff @(posedge clk) begin
        if (push_c) mem[wr_ptr] <= sel_entry_c;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push_c && !pop_c)      count <= count + COUNT_W'(1);
            else if (pop_c && !push_c) count <= count - COUNT_W'(1);
        end
    end

    // A drop in the same cycle as a clear keeps overflow set
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
            mask     <= '0;
        end else begin
            if (drop_c)         overflow <= 1'b1;
            else if (ovf_clr_c) overflow <= 1'b0;
            if (wr_req_c && bus.address == ADDR_MASK) mask <= bus.writedata[1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.readdata <= '0;
            bus.irq      <= 1'b0;
        end else begin
            bus.irq <= (mask[0] & ~empty_c) | (mask[1] & overflow);
            if (rd_req_c) begin
                unique case (bus.address)
                    ADDR_LEVEL:  bus.readdata <= 32'(stable);
                    ADDR_EVENT:  bus.readdata <= empty_c ? 32'd0 : {1'b1, 26'd0, mem[rd_ptr]};
                    ADDR_MASK:   bus.readdata <= {30'd0, mask};
                    ADDR_STATUS: bus.readdata <= {23'd0, overflow, 8'(count)};
                    default:     bus.readdata <= '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hps_button_event_ctrl.sv
// Directed bench for hps_button_event_ctrl: an event-level model is compared every cycle and
// hand-computed literals pin the model at key points.
module tb_hps_button_event_ctrl;

    localparam int DEB   = 16;
    localparam int DEPTH = 8;

    logic       clk;
    logic       reset;
    logic [3:0] in_port;

    hps_button_event_ctrl_if bus ();

    hps_button_event_ctrl #(
        .NUM_BTN(4), .DEBOUNCE_CYCLES(DEB), .CNT_W(5), .FIFO_DEPTH(DEPTH), .IDLE_LEVEL(4'hF)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus), .in_port(in_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    // Model state: what software should observe, expressed as levels, timestamps and a queue
    logic [3:0]  m_d1, m_d2, m_stable, m_pend;
    int          m_t0 [4];
    logic [31:0] m_q [$];
    logic        m_ovf;
    logic [1:0]  m_mask;
    logic [31:0] m_rd;
    logic        m_irq;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, exp, cyc);
    endtask

    task automatic model_reset();
        m_d1 = 4'hF; m_d2 = 4'hF; m_stable = 4'hF; m_pend = '0;
        for (int i = 0; i < 4; i++) m_t0[i] = -1;
        m_q.delete();
        m_ovf = 1'b0; m_mask = '0; m_rd = '0; m_irq = 1'b0;
    endtask

    // One rising edge of the design, using the inputs held across that edge
    task automatic model_step();
        logic [31:0] rd_n;
        logic        irq_n;
        bit          pop, drop, wr;
        int          sel;
        cyc++;
        if (reset) begin
            model_reset();
            return;
        end
        rd_n  = m_rd;
        irq_n = (m_mask[0] && m_q.size() != 0) || (m_mask[1] && m_ovf);
        if (bus.read) begin
            case (bus.address)
                2'd0: rd_n = {28'd0, m_stable};
                2'd1: rd_n = (m_q.size() != 0) ? m_q[0] : 32'd0;
                2'd2: rd_n = {30'd0, m_mask};
                default: rd_n = {23'd0, m_ovf, 8'(m_q.size())};
            endcase
        end
        pop  = bus.read && bus.address == 2'd1 && m_q.size() != 0;
        wr   = bus.write && !bus.read;
        drop = 0;
        sel  = -1;
        for (int i = 3; i >= 0; i--) if (m_pend[i]) sel = i;
        if (pop) void'(m_q.pop_front());
        if (sel >= 0) begin
            if (m_q.size() < DEPTH) m_q.push_back({1'b1, 26'd0, m_stable[sel], 4'(sel)});
            else drop = 1;
            m_pend[sel] = 1'b0;
        end
        if (wr && bus.address == 2'd3 && bus.writedata[8]) m_ovf = 1'b0;
        if (drop) m_ovf = 1'b1;
        if (wr && bus.address == 2'd2) m_mask = bus.writedata[1:0];
        // A level is taken once the synchronised pin has differed for DEB edges in a row
        for (int i = 0; i < 4; i++) begin
            if (m_d2[i] == m_stable[i]) m_t0[i] = -1;
            else begin
                if (m_t0[i] < 0) m_t0[i] = cyc;
                if (cyc - m_t0[i] == DEB - 1) begin
                    m_stable[i] = m_d2[i];
                    m_pend[i]   = 1'b1;
                    m_t0[i]     = -1;
                end
            end
        end
        m_d2  = m_d1;
        m_d1  = in_port;
        m_rd  = rd_n;
        m_irq = irq_n;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("readdata", bus.readdata, m_rd);
        check("irq", 32'(bus.irq), 32'(m_irq));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic bus_read(input logic [1:0] addr);
        bus.read = 1'b1; bus.address = addr;
        tick();
        bus.read = 1'b0;
    endtask

    task automatic read_expect(input logic [1:0] addr, input logic [31:0] exp, input string name);
        bus_read(addr);
        check(name, bus.readdata, exp);
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        bus.write = 1'b1; bus.address = addr; bus.writedata = data;
        tick();
        bus.write = 1'b0; bus.writedata = '0;
    endtask

    initial begin
        model_reset();
        reset = 1'b1; in_port = 4'hF;
        bus.read = 1'b0; bus.write = 1'b0; bus.address = '0; bus.writedata = '0;
        ticks(3);
        check("reset_readdata", bus.readdata, 32'h0);
        check("reset_irq", 32'(bus.irq), 32'h0);
        reset = 1'b0;
        ticks(30);
        read_expect(2'd3, 32'h0, "no_event_from_reset");

        // Bouncing press yields a single event
        for (int k = 0; k < 10; k++) begin
            in_port[0] = ~in_port[0];
            ticks(3);
        end
        in_port[0] = 1'b0;
        ticks(40);
        read_expect(2'd3, 32'h001, "bounce_status");
        read_expect(2'd0, 32'hE, "bounce_level");
        read_expect(2'd1, 32'h8000_0000, "bounce_press");
        read_expect(2'd1, 32'h0, "bounce_empty");
        in_port[0] = 1'b1;
        ticks(40);
        read_expect(2'd1, 32'h8000_0010, "bounce_release");

        // Two buttons accepted on the same edge drain in index order
        in_port = 4'h5;
        ticks(40);
        read_expect(2'd1, 32'h8000_0001, "simul_first");
        read_expect(2'd1, 32'h8000_0003, "simul_second");
        read_expect(2'd0, 32'h5, "simul_level");
        in_port = 4'hF;
        ticks(40);
        read_expect(2'd1, 32'h8000_0011, "simul_rel1");
        read_expect(2'd1, 32'h8000_0013, "simul_rel3");

        // Nine events into an eight-entry queue
        for (int k = 0; k < 9; k++) begin
            in_port[0] = ~in_port[0];
            ticks(24);
        end
        read_expect(2'd3, 32'h108, "ovf_status");
        for (int k = 0; k < 8; k++)
            read_expect(2'd1, (k % 2 == 0) ? 32'h8000_0000 : 32'h8000_0010, "ovf_drain");
        read_expect(2'd1, 32'h0, "ovf_ninth_absent");
        bus_write(2'd3, 32'h100);
        read_expect(2'd3, 32'h000, "ovf_cleared");
        in_port[0] = 1'b1;
        ticks(24);
        read_expect(2'd1, 32'h8000_0010, "ovf_restore");

        // Pop on the same edge as a push into a full queue
        for (int k = 0; k < 8; k++) begin
            in_port[0] = ~in_port[0];
            ticks(24);
        end
        read_expect(2'd3, 32'h008, "full_before");
        in_port[1] = 1'b0;
        ticks(18);
        read_expect(2'd1, 32'h8000_0000, "full_pop_head");
        read_expect(2'd3, 32'h008, "full_boundary_status");
        for (int k = 0; k < 7; k++) bus_read(2'd1);
        read_expect(2'd1, 32'h8000_0001, "full_last_entry");
        in_port[1] = 1'b1;
        ticks(24);
        read_expect(2'd1, 32'h8000_0011, "full_restore");

        // Interrupt on not-empty
        bus_write(2'd2, 32'h1);
        in_port[2] = 1'b0;
        ticks(19);
        check("irq_at_push", 32'(bus.irq), 32'h0);
        tick();
        check("irq_after_push", 32'(bus.irq), 32'h1);
        read_expect(2'd1, 32'h8000_0002, "irq_event");
        tick();
        check("irq_after_pop", 32'(bus.irq), 32'h0);
        bus.write = 1'b1; bus.writedata = 32'h3;
        read_expect(2'd2, 32'h1, "rw_same_cycle");
        bus.write = 1'b0; bus.writedata = '0;
        read_expect(2'd2, 32'h1, "mask_unchanged");
        bus_write(2'd2, 32'h0);
        in_port[2] = 1'b1;
        ticks(30);
        check("irq_masked", 32'(bus.irq), 32'h0);
        read_expect(2'd3, 32'h001, "masked_status");
        read_expect(2'd1, 32'h8000_0012, "masked_event");

        // Reset with queued events and a debounce in flight
        bus_write(2'd2, 32'h1);
        in_port = 4'h8;
        ticks(25);
        read_expect(2'd0, 32'h8, "pre_reset_level");
        check("pre_reset_irq", 32'(bus.irq), 32'h1);
        in_port = 4'h0;
        ticks(10);
        reset = 1'b1;
        #1;
        check("async_reset_readdata", bus.readdata, 32'h0);
        check("async_reset_irq", 32'(bus.irq), 32'h0);
        in_port = 4'hF;
        ticks(2);
        reset = 1'b0;
        ticks(40);
        read_expect(2'd3, 32'h0, "post_reset_status");
        read_expect(2'd1, 32'h0, "post_reset_event");
        read_expect(2'd2, 32'h0, "post_reset_mask");
        read_expect(2'd0, 32'hF, "post_reset_level");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
